// File: rtl/mask_buffer.sv
// Single-clock byte-maskable mask store with a built-in zeroing sweep (DEPTH cycles).
// Reads return data one cycle after the strobe, write-first on same-address collisions; writes are dropped while sweeping or when out of range.
module mask_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 9600,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    startClear,
  output logic                    clearBusy,
  input  logic                    writeEnable,
  input  logic [ADDR_WIDTH-1:0]   writeAddress,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  input  logic [DATA_WIDTH-1:0]   dataIn,
  output logic                    writeDropped,
  input  logic                    readEnable,
  input  logic [ADDR_WIDTH-1:0]   readAddress,
  output logic                    readValid,
  output logic [DATA_WIDTH-1:0]   dataOut
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] clear_addr, clear_addr_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [NB-1:0]         mem_mask;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_merged;
  logic [DATA_WIDTH-1:0] rd_next;

  // Sweep controller
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      clear_addr <= '0;
    end else begin
      state      <= state_n;
      clear_addr <= clear_addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    clear_addr_n = clear_addr;
    case (state)
      IDLE: begin
        if (startClear) begin
          state_n      = CLEAR;
          clear_addr_n = '0;
        end
      end
      CLEAR: begin
        if (startClear) begin
          clear_addr_n = '0;
        end else if (clear_addr == LAST_ADDR) begin
          state_n      = IDLE;
          clear_addr_n = '0;
        end else begin
          clear_addr_n = clear_addr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_n      = CLEAR;
        clear_addr_n = '0;
      end
    endcase
  end

  assign clearBusy   = (state == CLEAR);
  assign wr_in_range = (writeAddress <= LAST_ADDR);
  assign rd_in_range = (readAddress <= LAST_ADDR);
  assign wr_accept   = writeEnable && !clearBusy && wr_in_range;

  // The sweep owns the single write port; user writes only land in IDLE.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = writeAddress;
    mem_mask = byteEnable;
    mem_data = dataIn;
    if (reset) begin
      mem_we = 1'b0;
    end else if (clearBusy) begin
      mem_we   = 1'b1;
      mem_addr = clear_addr;
      mem_mask = '1;
      mem_data = '0;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_mask[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first bypass merges only the enabled lanes over the stored word.
  always_comb begin
    rd_word   = mem[readAddress];
    rd_merged = rd_word;
    if (wr_accept && (writeAddress == readAddress)) begin
      for (int i = 0; i < NB; i++) begin
        if (byteEnable[i]) begin
          rd_merged[8*i +: 8] = dataIn[8*i +: 8];
        end
      end
    end
    rd_next = rd_merged;
    if (clearBusy || !rd_in_range) begin
      rd_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readValid    <= 1'b0;
      dataOut      <= '0;
      writeDropped <= 1'b0;
    end else begin
      readValid    <= readEnable;
      writeDropped <= writeEnable && !wr_accept;
      if (readEnable) begin
        dataOut <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_mask_buffer.sv
// Directed bench for mask_buffer: vector table for the steady-state port behaviour,
// hand sequences for the clear sweep, its restart paths and sweep-time drops/reads.
module tb_mask_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        startClear;
  logic        clearBusy;
  logic        writeEnable;
  logic [13:0] writeAddress;
  logic [3:0]  byteEnable;
  logic [31:0] dataIn;
  logic        writeDropped;
  logic        readEnable;
  logic [13:0] readAddress;
  logic        readValid;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

  mask_buffer #(.DATA_WIDTH(32), .DEPTH(9600), .ADDR_WIDTH(14)) dut (
    .clock       (clock),
    .reset       (reset),
    .startClear  (startClear),
    .clearBusy   (clearBusy),
    .writeEnable (writeEnable),
    .writeAddress(writeAddress),
    .byteEnable  (byteEnable),
    .dataIn      (dataIn),
    .writeDropped(writeDropped),
    .readEnable  (readEnable),
    .readAddress (readAddress),
    .readValid   (readValid),
    .dataOut     (dataOut)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [13:0] waddr;
    logic [3:0]  be;
    logic [31:0] din;
    logic        re;
    logic [13:0] raddr;
    logic        exp_valid;
    logic [31:0] exp_dout;
    logic        exp_drop;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic we, input int waddr, input logic [3:0] be,
                              input logic [31:0] din, input logic re, input int raddr,
                              input logic ev, input logic [31:0] ed, input logic edr);
    vec_t v;
    v.we = we; v.waddr = 14'(waddr); v.be = be; v.din = din;
    v.re = re; v.raddr = 14'(raddr);
    v.exp_valid = ev; v.exp_dout = ed; v.exp_drop = edr;
    return v;
  endfunction

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    startClear = 1'b0; writeEnable = 1'b0; writeAddress = '0; byteEnable = '0;
    dataIn = '0; readEnable = 1'b0; readAddress = '0;
  endtask

  task automatic do_write(input int addr, input logic [3:0] be, input logic [31:0] d);
    writeEnable = 1'b1; writeAddress = 14'(addr); byteEnable = be; dataIn = d;
    cycle();
    writeEnable = 1'b0;
  endtask

  task automatic do_read(input string name, input int addr, input logic [31:0] exp);
    readEnable = 1'b1; readAddress = 14'(addr);
    cycle();
    readEnable = 1'b0;
    check({name, " valid"}, 32'(readValid), 32'd1);
    check({name, " data"}, dataOut, exp);
    cycle();
    check({name, " valid drop"}, 32'(readValid), 32'd0);
    check({name, " data hold"}, dataOut, exp);
  endtask

  // Counts busy cycles, including the current one already observed busy (start).
  task automatic run_busy(input string name, input int start);
    int n;
    n = start;
    while (clearBusy === 1'b1 && n < 20000) begin
      cycle();
      if (clearBusy === 1'b1) n++;
    end
    check(name, 32'(n), 32'd9600);
  endtask

  task automatic pulse_clear();
    startClear = 1'b1;
    cycle();
    startClear = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) cycle();
    check("rst clearBusy", 32'(clearBusy), 32'd1);
    check("rst readValid", 32'(readValid), 32'd0);
    check("rst dataOut", dataOut, 32'd0);
    check("rst writeDropped", 32'(writeDropped), 32'd0);
    reset = 1'b0;
    run_busy("initial sweep length", 1);

    do_read("post-clear rd 0", 0, 32'h0);
    do_read("post-clear rd 4711", 4711, 32'h0);
    do_read("post-clear rd 9599", 9599, 32'h0);

    vecs[0]  = mk(1, 100,   4'hF, 32'hDEADBEEF, 0, 0,     0, 32'h00000000, 0);
    vecs[1]  = mk(1, 100,   4'h5, 32'h11223344, 0, 0,     0, 32'h00000000, 0);
    vecs[2]  = mk(0, 0,     4'h0, 32'h0,        1, 100,   1, 32'hDE22BE44, 0);
    vecs[3]  = mk(1, 200,   4'hF, 32'hAAAAAAAA, 0, 0,     0, 32'hDE22BE44, 0);
    vecs[4]  = mk(1, 200,   4'h3, 32'hCAFEF00D, 1, 200,   1, 32'hAAAAF00D, 0);
    vecs[5]  = mk(0, 0,     4'h0, 32'h0,        1, 200,   1, 32'hAAAAF00D, 0);
    vecs[6]  = mk(1, 0,     4'hF, 32'h55AA55AA, 0, 0,     0, 32'hAAAAF00D, 0);
    vecs[7]  = mk(1, 9600,  4'hF, 32'hFFFFFFFF, 0, 0,     0, 32'hAAAAF00D, 1);
    vecs[8]  = mk(1, 16383, 4'hF, 32'hFFFFFFFF, 0, 0,     0, 32'hAAAAF00D, 1);
    vecs[9]  = mk(0, 0,     4'h0, 32'h0,        0, 0,     0, 32'hAAAAF00D, 0);
    vecs[10] = mk(0, 0,     4'h0, 32'h0,        1, 9600,  1, 32'h00000000, 0);
    vecs[11] = mk(0, 0,     4'h0, 32'h0,        1, 0,     1, 32'h55AA55AA, 0);
    vecs[12] = mk(1, 300,   4'hF, 32'h99887766, 0, 0,     0, 32'h55AA55AA, 0);
    vecs[13] = mk(1, 300,   4'h0, 32'h01020304, 1, 300,   1, 32'h99887766, 0);
    vecs[14] = mk(1, 400,   4'hF, 32'h0BADF00D, 1, 100,   1, 32'hDE22BE44, 0);
    vecs[15] = mk(0, 0,     4'h0, 32'h0,        1, 400,   1, 32'h0BADF00D, 0);
    vecs[16] = mk(0, 0,     4'h0, 32'h0,        1, 16383, 1, 32'h00000000, 0);
    vecs[17] = mk(1, 500,   4'hF, 32'hFFFFFFFF, 1, 500,   1, 32'hFFFFFFFF, 0);

    for (int k = 0; k < 18; k++) begin
      writeEnable = vecs[k].we; writeAddress = vecs[k].waddr;
      byteEnable = vecs[k].be; dataIn = vecs[k].din;
      readEnable = vecs[k].re; readAddress = vecs[k].raddr;
      cycle();
      check($sformatf("vec%0d readValid", k), 32'(readValid), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d dataOut", k), dataOut, vecs[k].exp_dout);
      check($sformatf("vec%0d writeDropped", k), 32'(writeDropped), 32'(vecs[k].exp_drop));
    end
    idle_inputs();
    cycle();

    // Commanded clear with a write and a read landing inside the sweep.
    do_write(5, 4'hF, 32'h12345678);
    do_read("fill rd 5", 5, 32'h12345678);
    pulse_clear();
    check("start busy", 32'(clearBusy), 32'd1);
    writeEnable = 1'b1; writeAddress = 14'd7; byteEnable = 4'hF; dataIn = 32'hFFFFFFFF;
    readEnable = 1'b1; readAddress = 14'd5;
    cycle();
    idle_inputs();
    check("sweep drop", 32'(writeDropped), 32'd1);
    check("sweep rd valid", 32'(readValid), 32'd1);
    check("sweep rd data", dataOut, 32'h0);
    cycle();
    check("sweep drop one-shot", 32'(writeDropped), 32'd0);
    run_busy("commanded sweep length", 3);
    do_read("after clear rd 5", 5, 32'h0);
    do_read("after clear rd 7", 7, 32'h0);

    // startClear mid-sweep restarts from address 0.
    pulse_clear();
    repeat (3000) cycle();
    check("mid sweep busy", 32'(clearBusy), 32'd1);
    pulse_clear();
    check("restart busy", 32'(clearBusy), 32'd1);
    run_busy("restart by startClear length", 1);

    // Reset mid-sweep also restarts from address 0.
    do_write(9, 4'hF, 32'hA5A5A5A5);
    pulse_clear();
    repeat (3000) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("reset restart busy", 32'(clearBusy), 32'd1);
    check("reset restart readValid", 32'(readValid), 32'd0);
    run_busy("restart by reset length", 1);
    do_read("after reset sweep rd 9", 9, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
